ov7670_dvp_tx: RTL and testbench
================================

OV7670_DVP_TX -- requirements
Module: ov7670_dvp_tx

Interface
REQ-001 Parameter H_ACTIVE, default 320, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 240, active lines per frame.
REQ-003 Parameter H_BLANK, default 144, pclk cycles with href low after each active line.
REQ-004 Parameter VSYNC_LINES, default 3, line periods with vsync high.
REQ-005 Parameter V_BP, default 17, and V_FP, default 10, back/front-porch line periods.
REQ-006 pclk  input  1  single clock; all outputs change on rising edge only.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 enable  input  1  start/continue frame generation.
REQ-009 test_pattern  input  1  select internal colour bars instead of BRAM data.
REQ-010 bram_addr  output  17  pixel read address, linear raster order.
REQ-011 bram_data  input  16  RGB565 word; synchronous BRAM, read latency exactly 1 pclk.
REQ-012 vsync  output  1  frame sync, active high.
REQ-013 href  output  1  line valid, active high.
REQ-014 data  output  8  pixel byte stream.
REQ-015 frame_done  output  1  one-cycle pulse after last pixel byte of a frame.

Function
REQ-016 States: IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP; LINE_LEN = 2*H_ACTIVE + H_BLANK cycles.
REQ-017 IDLE -> VSYNC when enable=1; vsync high for exactly VSYNC_LINES*LINE_LEN cycles.
REQ-018 VBP lasts V_BP*LINE_LEN cycles, vsync and href low.
REQ-019 Each line: ACTIVE for 2*H_ACTIVE cycles with href=1, then HBLANK for H_BLANK cycles with href=0; repeated V_ACTIVE times.
REQ-020 After last line's HBLANK, VFP for V_FP*LINE_LEN cycles; then VSYNC if enable=1, else IDLE.
REQ-021 Each pixel occupies two consecutive href cycles: first data=word[15:8] (RRRRRGGG), second data=word[7:0] (GGGBBBBB).
REQ-022 data SHALL be 8'h00 whenever href=0.
REQ-023 bram_addr=N driven exactly 2 cycles before the high-byte cycle of pixel N; word captured in a holding register the following cycle.
REQ-024 Pixel N = line*H_ACTIVE + column; bram_addr returns to 0 during VBP, never exceeds H_ACTIVE*V_ACTIVE-1.
REQ-025 frame_done pulses in the first VFP cycle.
REQ-026 enable deasserted mid-frame: current frame completes through VFP, then IDLE; no truncated line.
REQ-027 test_pattern sampled only on VSYNC entry; constant for whole frame.

Reset
REQ-028 rst_n low: state IDLE, vsync=0, href=0, data=8'h00, bram_addr=0, frame_done=0, all counters 0, asynchronously.
REQ-029 Reset mid-frame aborts immediately; after release, next frame begins from VSYNC with pixel 0.

Configuration
REQ-030 Macro OV7670_DVP_TX_PATTERN_EN defined: test_pattern=1 outputs 8 equal-width vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black, RGB565), bram_addr still sequenced.
REQ-031 Macro undefined: colour-bar logic absent, test_pattern ignored, BRAM data always used.

Structure
REQ-032 Shared package ov7670_pkg holds state enum, default timing constants, RGB565 colour-bar constants and 17-bit address width.
REQ-033 Colour-bar generator is sub-module ov7670_colorbar (column in, RGB565 out), instantiated only under OV7670_DVP_TX_PATTERN_EN.

Verification
REQ-034 Bench params H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VSYNC_LINES=1, V_BP=1, V_FP=1 (LINE_LEN=11); BRAM word N = 16'hA500+N.
REQ-035 Reset release, enable=1 -> vsync high exactly 11 cycles, href low 11 cycles, then href high 8 cycles with data A5,00,A5,01,A5,02,A5,03.
REQ-036 Full frame -> second line bytes A5,04..A5,07, 3 href-low cycles between lines, frame_done single pulse, bram_addr max 7.
REQ-037 enable dropped during line 0 -> line 1 and VFP complete, frame_done pulses, then IDLE with vsync=0 steady.
REQ-038 rst_n asserted during ACTIVE -> outputs zero same cycle; after release, next frame starts at bram_addr 0.
REQ-039 Macro defined, H_ACTIVE=8, test_pattern=1 -> high bytes FF,FF,07,07,... (white, yellow, cyan...) one bar per pixel.

Source files
------------

// File: rtl/ov7670_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ov7670_pkg                                             |
// | Description : Shared definitions for the OV7670-style DVP            |
// |               transmitter: FSM state encoding, default timing,       |
// |               RGB565 colour-bar palette and address width.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ov7670_pkg;

  // Pixel read address width (covers 320x240 = 76800 pixels).
  localparam int c_addr_w = 17;
  // Column index width handed to the colour-bar generator.
  localparam int c_col_w  = 10;

  // Default VGA-ish QVGA timing.
  localparam int c_def_h_active    = 320;
  localparam int c_def_v_active    = 240;
  localparam int c_def_h_blank     = 144;
  localparam int c_def_vsync_lines = 3;
  localparam int c_def_v_bp        = 17;
  localparam int c_def_v_fp        = 10;

  // RGB565 colour-bar palette.
  localparam logic [15:0] c_white   = 16'hFFFF;
  localparam logic [15:0] c_yellow  = 16'hFFE0;
  localparam logic [15:0] c_cyan    = 16'h07FF;
  localparam logic [15:0] c_green   = 16'h07E0;
  localparam logic [15:0] c_magenta = 16'hF81F;
  localparam logic [15:0] c_red     = 16'hF800;
  localparam logic [15:0] c_blue    = 16'h001F;
  localparam logic [15:0] c_black   = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFP    = 3'd5
  } state_t;

  // Bar index 0..7 (left to right) to RGB565 colour.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] rgb;
    case (idx)
      3'd0:    rgb = c_white;
      3'd1:    rgb = c_yellow;
      3'd2:    rgb = c_cyan;
      3'd3:    rgb = c_green;
      3'd4:    rgb = c_magenta;
      3'd5:    rgb = c_red;
      3'd6:    rgb = c_blue;
      default: rgb = c_black;
    endcase
    return rgb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ov7670_colorbar.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ov7670_colorbar                                        |
// | Description : Eight equal-width vertical colour bars (white, yellow, |
// |               cyan, green, magenta, red, blue, black) in RGB565.     |
// |               Purely combinational.                                  |
// | Ports       : col [c_col_w] in  - active pixel column                |
// |               rgb [16]      out - RGB565 colour of that column       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ov7670_colorbar
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = c_def_h_active
) (
  input  logic [c_col_w-1:0] col,
  output logic [15:0]        rgb
);

  localparam logic [c_col_w+2:0] c_h     = (c_col_w + 3)'(H_ACTIVE);
  localparam logic [c_col_w+2:0] c_max_b = (c_col_w + 3)'(7);

  logic [c_col_w+2:0] w_scaled;
  logic [c_col_w+2:0] w_bar;

  // bar = floor(col * 8 / H_ACTIVE); divisor is a constant.
  assign w_scaled = {col, 3'b000};
  assign w_bar    = w_scaled / c_h;
  assign rgb      = (w_bar > c_max_b) ? c_black : bar_color(w_bar[2:0]);

endmodule
`default_nettype wire

// File: rtl/ov7670_dvp_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ov7670_dvp_tx                                          |
// | Description : Generates an OV7670-style DVP stream (vsync/href/8-bit |
// |               data, RGB565 as two bytes per pixel) from a 1-cycle    |
// |               latency BRAM frame buffer.                             |
// | Ports       : pclk, rst_n (async, active low)                        |
// |               enable       in  - start/continue frame generation     |
// |               test_pattern in  - colour bars instead of BRAM data    |
// |               bram_addr    out - linear raster pixel address         |
// |               bram_data    in  - RGB565 word, 1 pclk after address   |
// |               vsync, href  out - frame / line sync, active high      |
// |               data         out - pixel byte, 0 while href is low     |
// |               frame_done   out - pulse in the first front-porch cycle|
// | Options     : OV7670_DVP_TX_PATTERN_EN enables the colour-bar path;  |
// |               without it test_pattern is ignored.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ov7670_dvp_tx
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE    = c_def_h_active,
  parameter int V_ACTIVE    = c_def_v_active,
  parameter int H_BLANK     = c_def_h_blank,
  parameter int VSYNC_LINES = c_def_vsync_lines,
  parameter int V_BP        = c_def_v_bp,
  parameter int V_FP        = c_def_v_fp
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                test_pattern,
  output logic [c_addr_w-1:0] bram_addr,
  input  logic [15:0]         bram_data,
  output logic                vsync,
  output logic                href,
  output logic [7:0]          data,
  output logic                frame_done
);

  // Address prefetch runs two cycles ahead of the byte stream, so the
  // blanking gap (H_BLANK) and back porch must each be at least 2 cycles.
  localparam int c_line_len = 2 * H_ACTIVE + H_BLANK;
  localparam int c_hw       = $clog2(c_line_len + 2);
  localparam int c_vw       = 12;

  localparam logic [c_hw-1:0] c_h_last   = c_hw'(c_line_len - 1);
  localparam logic [c_hw-1:0] c_act_last = c_hw'(2 * H_ACTIVE - 1);
  localparam logic [c_hw-1:0] c_two_h    = c_hw'(2 * H_ACTIVE);
  localparam logic [c_hw-1:0] c_ll       = c_hw'(c_line_len);
  localparam logic [c_hw-1:0] c_two      = c_hw'(2);

  localparam logic [c_vw-1:0] c_vs_last = c_vw'(VSYNC_LINES - 1);
  localparam logic [c_vw-1:0] c_bp_last = c_vw'(V_BP - 1);
  localparam logic [c_vw-1:0] c_va_last = c_vw'(V_ACTIVE - 1);
  localparam logic [c_vw-1:0] c_fp_last = c_vw'(V_FP - 1);

  localparam logic [c_addr_w-1:0] c_h_addr = c_addr_w'(H_ACTIVE);
  localparam logic [c_addr_w-1:0] c_h_m1   = c_addr_w'(H_ACTIVE - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_hw-1:0]     r_hcnt;      // cycle within the current line period
  logic [c_hw-1:0]     w_hcnt_nxt;
  logic [c_vw-1:0]     r_vcnt;      // line within the current phase
  logic [c_vw-1:0]     w_vcnt_nxt;
  logic [c_addr_w-1:0] r_base;      // address of column 0 of the current line
  logic [15:0]         r_word;      // holding register for the pixel on the wire
  logic [15:0]         w_pix;
  logic [c_hw-1:0]     w_q;
  logic                w_line_end;

  assign w_line_end = (r_hcnt == c_h_last);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_hcnt  <= '0;
      r_vcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_vcnt  <= w_vcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt + 1'b1;
    w_vcnt_nxt  = r_vcnt;
    case (r_state)
      ST_IDLE: begin
        w_hcnt_nxt = '0;
        w_vcnt_nxt = '0;
        if (enable) w_state_nxt = ST_VSYNC;
      end
      ST_VSYNC: begin
        if (w_line_end) begin
          w_hcnt_nxt = '0;
          if (r_vcnt == c_vs_last) begin
            w_vcnt_nxt  = '0;
            w_state_nxt = ST_VBP;
          end else begin
            w_vcnt_nxt = r_vcnt + 1'b1;
          end
        end
      end
      ST_VBP: begin
        if (w_line_end) begin
          w_hcnt_nxt = '0;
          if (r_vcnt == c_bp_last) begin
            w_vcnt_nxt  = '0;
            w_state_nxt = ST_ACTIVE;
          end else begin
            w_vcnt_nxt = r_vcnt + 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        // hcnt keeps running into HBLANK; one counter spans the whole line.
        if (r_hcnt == c_act_last) w_state_nxt = ST_HBLANK;
      end
      ST_HBLANK: begin
        if (w_line_end) begin
          w_hcnt_nxt = '0;
          if (r_vcnt == c_va_last) begin
            w_vcnt_nxt  = '0;
            w_state_nxt = ST_VFP;
          end else begin
            w_vcnt_nxt  = r_vcnt + 1'b1;
            w_state_nxt = ST_ACTIVE;
          end
        end
      end
      ST_VFP: begin
        // enable is only consulted here, so frames are never truncated.
        if (w_line_end) begin
          w_hcnt_nxt = '0;
          if (r_vcnt == c_fp_last) begin
            w_vcnt_nxt  = '0;
            w_state_nxt = enable ? ST_VSYNC : ST_IDLE;
          end else begin
            w_vcnt_nxt = r_vcnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_hcnt_nxt  = '0;
        w_vcnt_nxt  = '0;
      end
    endcase
  end

  // ------------------------------------------------- line base / holding
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= '0;
      r_word <= '0;
    end else begin
      if (r_state == ST_HBLANK && w_state_nxt == ST_ACTIVE)
        r_base <= r_base + c_h_addr;
      else if (r_state != ST_ACTIVE && r_state != ST_HBLANK)
        r_base <= '0;
      // Latch the BRAM word on the edge that starts a high-byte cycle.
      if (w_state_nxt == ST_ACTIVE && !w_hcnt_nxt[0])
        r_word <= bram_data;
    end
  end

  // --------------------------------------------------------- addressing
  // bram_addr shows pixel N during the two cycles before N's high byte.
  // w_q is the line position two cycles ahead; positions past the end of
  // the line wrap onto column 0 of the next line, and the last address of
  // the frame is held instead of running past it.
  always_comb begin
    w_q       = r_hcnt + c_two;
    bram_addr = '0;
    if (r_state == ST_ACTIVE || r_state == ST_HBLANK) begin
      if (w_q < c_two_h)
        bram_addr = r_base + c_addr_w'(w_q >> 1);
      else if (w_q >= c_ll && r_vcnt != c_va_last)
        bram_addr = r_base + c_h_addr;
      else
        bram_addr = r_base + c_h_m1;
    end
  end

  // ------------------------------------------------------ pixel source
`ifdef OV7670_DVP_TX_PATTERN_EN
  logic        r_pat;
  logic [15:0] w_bar_rgb;

  // Pattern select is frozen on VSYNC entry for the whole frame.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)
      r_pat <= 1'b0;
    else if (w_state_nxt == ST_VSYNC && r_state != ST_VSYNC)
      r_pat <= test_pattern;
  end

  ov7670_colorbar #(
    .H_ACTIVE (H_ACTIVE)
  ) u_colorbar (
    .col (c_col_w'(r_hcnt >> 1)),
    .rgb (w_bar_rgb)
  );

  assign w_pix = r_pat ? w_bar_rgb : r_word;
`else
  logic w_unused_test_pattern;
  assign w_unused_test_pattern = test_pattern;
  assign w_pix = r_word;
`endif

  // ------------------------------------------------------------ outputs
  assign vsync      = (r_state == ST_VSYNC);
  assign href       = (r_state == ST_ACTIVE);
  assign data       = href ? (r_hcnt[0] ? w_pix[7:0] : w_pix[15:8]) : 8'h00;
  assign frame_done = (r_state == ST_VFP) && (r_hcnt == '0) && (r_vcnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_ov7670_dvp_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ov7670_dvp_tx                                       |
// | Description : Directed self-checking bench for ov7670_dvp_tx with a  |
// |               4x2 frame (LINE_LEN = 11) and BRAM word N = A500+N.    |
// |               With OV7670_DVP_TX_PATTERN_EN a second 8-wide instance |
// |               checks the colour bars.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ov7670_dvp_tx;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        test_pattern;
  logic [16:0] bram_addr;
  logic [15:0] bram_data = 16'h0000;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        frame_done;

  int          total = 0;
  int          bad   = 0;
  logic [16:0] max_addr;

  always #5 pclk = ~pclk;

  ov7670_dvp_tx #(
    .H_ACTIVE    (4),
    .V_ACTIVE    (2),
    .H_BLANK     (3),
    .VSYNC_LINES (1),
    .V_BP        (1),
    .V_FP        (1)
  ) u_dut (
    .pclk         (pclk),
    .rst_n        (rst_n),
    .enable       (enable),
    .test_pattern (test_pattern),
    .bram_addr    (bram_addr),
    .bram_data    (bram_data),
    .vsync        (vsync),
    .href         (href),
    .data         (data),
    .frame_done   (frame_done)
  );

  // Synchronous BRAM, one cycle read latency.
  always @(posedge pclk) bram_data <= 16'hA500 + bram_addr[15:0];

`ifdef OV7670_DVP_TX_PATTERN_EN
  logic        enable2;
  logic        tp2;
  logic [16:0] bram_addr2;
  logic [15:0] bram_data2 = 16'h0000;
  logic        vsync2;
  logic        href2;
  logic [7:0]  data2;
  logic        frame_done2;

  ov7670_dvp_tx #(
    .H_ACTIVE    (8),
    .V_ACTIVE    (2),
    .H_BLANK     (3),
    .VSYNC_LINES (1),
    .V_BP        (1),
    .V_FP        (1)
  ) u_dut_pat (
    .pclk         (pclk),
    .rst_n        (rst_n),
    .enable       (enable2),
    .test_pattern (tp2),
    .bram_addr    (bram_addr2),
    .bram_data    (bram_data2),
    .vsync        (vsync2),
    .href         (href2),
    .data         (data2),
    .frame_done   (frame_done2)
  );

  always @(posedge pclk) bram_data2 <= 16'hA500 + bram_addr2[15:0];
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
    if (bram_addr > max_addr) max_addr = bram_addr;
  endtask

  // Follows one frame from the vsync rise through the frame_done pulse.
  task automatic collect_frame(input bit drop_en);
    int n;
    int exp_v;
    n = 0;
    while (vsync !== 1'b1 && n < 100) begin step(); n++; end
    chk("vsync_rise", vsync, 1);
    chk("vsync_addr0", bram_addr, 0);
    max_addr = '0;
    n = 0;
    while (vsync === 1'b1 && n < 100) begin n++; step(); end
    chk("vsync_len", n, 11);
    chk("vbp_addr", bram_addr, 0);
    n = 0;
    while (href !== 1'b1 && n < 100) begin n++; step(); end
    chk("vbp_len", n, 11);
    for (int ln = 0; ln < 2; ln++) begin
      for (int b = 0; b < 8; b++) begin
        exp_v = (b % 2 == 1) ? (ln * 4 + b / 2) : 'hA5;
        chk("href_hi", href, 1);
        chk((b % 2 == 1) ? "lo_byte" : "hi_byte", data, exp_v);
        if (drop_en && ln == 0 && b == 3) enable = 1'b0;
        step();
      end
      n = 0;
      while (href !== 1'b1 && frame_done !== 1'b1 && n < 100) begin
        chk("blank_data", data, 0);
        n++;
        step();
      end
      chk((ln == 0) ? "hblank_len" : "fd_delay", n, 3);
    end
    chk("fd_pulse", frame_done, 1);
    chk("max_addr", max_addr, 7);
    step();
    chk("fd_single", frame_done, 0);
  endtask

  initial begin
    int n_vs;
    int n_hr;
    rst_n        = 1'b0;
    enable       = 1'b0;
    test_pattern = 1'b0;
    max_addr     = '0;
`ifdef OV7670_DVP_TX_PATTERN_EN
    enable2 = 1'b0;
    tp2     = 1'b1;
`endif
    repeat (3) step();
    chk("rst_vsync", vsync, 0);
    chk("rst_href", href, 0);
    chk("rst_data", data, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_fd", frame_done, 0);

    // Frame 1: continuous enable.
    rst_n  = 1'b1;
    enable = 1'b1;
    collect_frame(1'b0);

    // Frame 2 follows directly; enable drops during line 0.
    collect_frame(1'b1);
    n_vs = 0;
    n_hr = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (vsync !== 1'b0) n_vs++;
      if (href !== 1'b0) n_hr++;
    end
    chk("idle_vsync", n_vs, 0);
    chk("idle_href", n_hr, 0);
    chk("idle_addr", bram_addr, 0);

    // Frame 3: asynchronous reset in the middle of an active line.
    enable = 1'b1;
    n_vs = 0;
    while (href !== 1'b1 && n_vs < 100) begin step(); n_vs++; end
    repeat (3) step();
    chk("pre_rst_href", href, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_href", href, 0);
    chk("arst_data", data, 0);
    chk("arst_vsync", vsync, 0);
    chk("arst_addr", bram_addr, 0);
    chk("arst_fd", frame_done, 0);
    step();
    step();
`ifndef OV7670_DVP_TX_PATTERN_EN
    // Without the pattern option the select must have no effect.
    test_pattern = 1'b1;
`endif
    rst_n = 1'b1;
    collect_frame(1'b0);

`ifdef OV7670_DVP_TX_PATTERN_EN
    begin
      logic [7:0] hi_tab [8];
      logic [7:0] lo_tab [8];
      hi_tab = '{8'hFF, 8'hFF, 8'h07, 8'h07, 8'hF8, 8'hF8, 8'h00, 8'h00};
      lo_tab = '{8'hFF, 8'hE0, 8'hFF, 8'hE0, 8'h1F, 8'h00, 8'h1F, 8'h00};
      enable2 = 1'b1;
      n_vs = 0;
      while (href2 !== 1'b1 && n_vs < 200) begin step(); n_vs++; end
      chk("pat_href", href2, 1);
      for (int p = 0; p < 8; p++) begin
        chk("pat_hi", data2, hi_tab[p]);
        step();
        chk("pat_lo", data2, lo_tab[p]);
        step();
      end
      enable2 = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
